// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, drives a req/ready instruction memory,
// and feeds its own IF/ID register with stall, skid and redirect handling.
module stage_if #(
   parameter int unsigned   N        = 32,
   parameter logic [N-1:0]  RESET_PC = '0,
   parameter int unsigned   PC_STEP  = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          Stall_i,
   input  logic          BranchTaken_i,
   input  logic [N-1:0]  BranchTarget_i,
   output logic          IMemReq_o,
   output logic [N-1:0]  IMemAddr_o,
   input  logic [31:0]   IMemData_i,
   input  logic          IMemReady_i,
   output logic [31:0]   instruction_o,
   output logic [N-1:0]  PC_o,
   output logic [N-1:0]  PCPlus4_o,
   output logic          Valid_o
);

   localparam logic [N-1:0] STEP = N'(PC_STEP);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } state_t;

   typedef struct packed {
      logic [31:0]  instr;
      logic [N-1:0] pc;
      logic [N-1:0] pc4;
      logic         valid;
   } ifid_t;

   typedef struct packed {
      logic [31:0]  instr;
      logic [N-1:0] pc;
      logic         valid;
   } skid_t;

   state_t       state, state_n;
   logic [N-1:0] pc, pc_n;
   ifid_t        ifid, ifid_n;
   skid_t        skid, skid_n;

   logic is_idle;
   logic redirect;
   logic fetch_go;
   logic hold_go;

   // Decode terms are kept mutually exclusive so a one-hot case is exact.
   assign is_idle  = (state == IDLE);
   assign redirect = BranchTaken_i && !is_idle;
   assign fetch_go = (state == FETCH) && !BranchTaken_i;
   assign hold_go  = (state == HOLD) && !BranchTaken_i;

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ifid_n  = ifid;
      skid_n  = skid;
      unique case (1'b1)
         is_idle: begin
            state_n = FETCH;
         end
         redirect: begin
            pc_n    = {BranchTarget_i[N-1:2], 2'b00};
            ifid_n  = '0;
            skid_n  = '0;
            state_n = FETCH;
         end
         fetch_go && IMemReady_i && !Stall_i: begin
            ifid_n.instr = IMemData_i;
            ifid_n.pc    = pc;
            ifid_n.pc4   = pc + STEP;
            ifid_n.valid = 1'b1;
            pc_n         = pc + STEP;
         end
         fetch_go && IMemReady_i && Stall_i: begin
            skid_n.instr = IMemData_i;
            skid_n.pc    = pc;
            skid_n.valid = 1'b1;
            pc_n         = pc + STEP;
            state_n      = HOLD;
         end
         fetch_go && !IMemReady_i && !Stall_i: begin
            ifid_n = '0;
         end
         hold_go && !Stall_i: begin
            ifid_n.instr = skid.instr;
            ifid_n.pc    = skid.pc;
            ifid_n.pc4   = skid.pc + STEP;
            ifid_n.valid = 1'b1;
            skid_n       = '0;
            state_n      = FETCH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         pc    <= RESET_PC;
         ifid  <= '0;
         skid  <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         ifid  <= ifid_n;
         skid  <= skid_n;
      end
   end

   assign IMemReq_o     = (state == FETCH);
   assign IMemAddr_o    = pc;
   assign instruction_o = ifid.instr;
   assign PC_o          = ifid.pc;
   assign PCPlus4_o     = ifid.pc4;
   assign Valid_o       = ifid.valid;

endmodule
